// File: rtl/iob_uart_cfg_core.sv
// Configurable UART core: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits,
// runtime bit divisor, CTS-gated transmit and RTS flow control on the receive side.
module iob_uart_cfg_core #(
   parameter int DIV_W  = 16,
   parameter int SYNC_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tx_en_i,
   input  logic             rx_en_i,
   input  logic [1:0]       cfg_nbits_i,
   input  logic [1:0]       cfg_parity_i,
   input  logic             cfg_stop2_i,
   input  logic [DIV_W-1:0] bit_duration_i,
   input  logic [7:0]       tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic             tx_busy_o,
   output logic [7:0]       rx_data_o,
   output logic             rx_valid_o,
   input  logic             rx_ready_i,
   output logic             rx_parity_err_o,
   output logic             rx_frame_err_o,
   output logic             rx_overrun_o,
   input  logic             rs232_rxd_i,
   output logic             rs232_txd_o,
   input  logic             rs232_cts_i,
   output logic             rs232_rts_o
);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

   logic [DIV_W-1:0]  div_c, half_c;
   logic [SYNC_W-1:0] rxd_sync, cts_sync;
   logic              rxd_s, cts_s;

   always_comb begin
      div_c  = (bit_duration_i < DIV_W'(2)) ? DIV_W'(2) : bit_duration_i;
      half_c = div_c >> 1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rxd_sync <= '1;
         cts_sync <= '1;
      end else begin
         rxd_sync <= {rxd_sync[SYNC_W-2:0], rs232_rxd_i};
         cts_sync <= {cts_sync[SYNC_W-2:0], rs232_cts_i};
      end
   end

   assign rxd_s = rxd_sync[SYNC_W-1];
   assign cts_s = cts_sync[SYNC_W-1];

   // ---------------- transmitter ----------------
   tx_state_t        tx_state;
   logic [DIV_W-1:0] tx_cnt;
   logic [7:0]       tx_shift;
   logic [2:0]       tx_bit, tx_last;
   logic             tx_par, tx_par_en, tx_odd, tx_stop2, tx_stop_2nd, txd;
   logic             tx_bit_end;

   assign tx_bit_end  = (tx_cnt >= div_c - DIV_W'(1));
   assign tx_ready_o  = (tx_state == TX_IDLE) & tx_en_i & cts_s & ~rst_i;
   assign tx_busy_o   = (tx_state != TX_IDLE);
   assign rs232_txd_o = txd;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_state    <= TX_IDLE;
         tx_cnt      <= '0;
         tx_stop_2nd <= 1'b0;
         txd         <= 1'b1;
      end else begin
         if (tx_state == TX_IDLE) tx_cnt <= '0;
         else                     tx_cnt <= tx_bit_end ? '0 : tx_cnt + DIV_W'(1);
         case (tx_state)
            TX_IDLE: begin
               txd <= 1'b1;
               if (tx_valid_i && tx_ready_o) begin
                  tx_shift    <= tx_data_i;
                  tx_last     <= 3'd4 + {1'b0, cfg_nbits_i};
                  tx_par_en   <= ^cfg_parity_i;
                  tx_odd      <= cfg_parity_i[1];
                  tx_stop2    <= cfg_stop2_i;
                  tx_stop_2nd <= 1'b0;
                  tx_par      <= 1'b0;
                  tx_bit      <= '0;
                  txd         <= 1'b0;
                  tx_state    <= TX_START;
               end
            end
            TX_START: if (tx_bit_end) begin
               txd      <= tx_shift[0];
               tx_par   <= tx_par ^ tx_shift[0];
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_state <= TX_DATA;
            end
            TX_DATA: if (tx_bit_end) begin
               if (tx_bit == tx_last) begin
                  // parity accumulated over exactly the bits that went out
                  txd      <= tx_par_en ? (tx_par ^ tx_odd) : 1'b1;
                  tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
               end else begin
                  tx_bit   <= tx_bit + 3'd1;
                  txd      <= tx_shift[0];
                  tx_par   <= tx_par ^ tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
               end
            end
            TX_PARITY: if (tx_bit_end) begin
               txd      <= 1'b1;
               tx_state <= TX_STOP;
            end
            TX_STOP: if (tx_bit_end) begin
               txd <= 1'b1;
               if (tx_stop2 && !tx_stop_2nd) tx_stop_2nd <= 1'b1;
               else                          tx_state    <= TX_IDLE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   rx_state_t        rx_state;
   logic [DIV_W-1:0] rx_cnt;
   logic [7:0]       rx_buf;
   logic [2:0]       rx_bit, rx_last;
   logic             rx_par, rx_par_en, rx_odd, rx_perr, rx_sample;

   always_comb begin
      rx_sample = 1'b0;
      case (rx_state)
         RX_START:                     rx_sample = (rx_cnt >= half_c - DIV_W'(1));
         RX_DATA, RX_PARITY, RX_STOP:  rx_sample = (rx_cnt >= div_c - DIV_W'(1));
         default:                      rx_sample = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_state        <= RX_IDLE;
         rx_cnt          <= '0;
         rx_data_o       <= '0;
         rx_valid_o      <= 1'b0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_overrun_o    <= 1'b0;
         rs232_rts_o     <= 1'b0;
      end else begin
         rs232_rts_o <= rx_en_i & ~rx_valid_o;
         if (rx_ready_i && rx_valid_o) begin
            rx_valid_o      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
         end
         if (!rx_en_i || rx_sample || rx_state == RX_IDLE || rx_state == RX_BREAK)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + DIV_W'(1);
         if (!rx_en_i) begin
            rx_state <= RX_IDLE;
         end else begin
            case (rx_state)
               RX_IDLE: if (!rxd_s) begin
                  rx_last   <= 3'd4 + {1'b0, cfg_nbits_i};
                  rx_par_en <= ^cfg_parity_i;
                  rx_odd    <= cfg_parity_i[1];
                  rx_buf    <= '0;
                  rx_bit    <= '0;
                  rx_par    <= 1'b0;
                  rx_perr   <= 1'b0;
                  rx_state  <= RX_START;
               end
               RX_START: if (rx_sample) rx_state <= rxd_s ? RX_IDLE : RX_DATA;
               RX_DATA: if (rx_sample) begin
                  rx_buf[rx_bit] <= rxd_s;
                  rx_par         <= rx_par ^ rxd_s;
                  if (rx_bit == rx_last) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                  else                   rx_bit   <= rx_bit + 3'd1;
               end
               RX_PARITY: if (rx_sample) begin
                  rx_perr  <= rxd_s ^ rx_par ^ rx_odd;
                  rx_state <= RX_STOP;
               end
               RX_STOP: if (rx_sample) begin
                  // a read in this same cycle leaves the new frame valid without overrun
                  rx_data_o       <= rx_buf;
                  rx_valid_o      <= 1'b1;
                  rx_parity_err_o <= rx_perr;
                  rx_frame_err_o  <= ~rxd_s;
                  rx_overrun_o    <= rx_valid_o & ~rx_ready_i;
                  rx_state        <= rxd_s ? RX_IDLE : RX_BREAK;
               end
               RX_BREAK: if (rxd_s) rx_state <= RX_IDLE;
               default:  rx_state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iob_uart_cfg_core.sv
// Directed bench for iob_uart_cfg_core: TX waveform, loopback, injected RX frames,
// overrun, glitch rejection, reset mid-frame and CTS gating.
module tb_iob_uart_cfg_core;

   logic        clk = 1'b0;
   logic        rst, tx_en, rx_en, stop2, tx_valid, tx_ready, tx_busy;
   logic        rx_valid, rx_ready, perr, ferr, ovr, rxd, txd, cts, rts;
   logic        rxd_drv, loop;
   logic [1:0]  nbits, parity;
   logic [15:0] div;
   logic [7:0]  tx_data, rx_data;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign rxd = loop ? txd : rxd_drv;

   iob_uart_cfg_core #(.DIV_W(16), .SYNC_W(2)) dut (
      .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .rx_en_i(rx_en),
      .cfg_nbits_i(nbits), .cfg_parity_i(parity), .cfg_stop2_i(stop2),
      .bit_duration_i(div), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready), .tx_busy_o(tx_busy), .rx_data_o(rx_data),
      .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_parity_err_o(perr),
      .rx_frame_err_o(ferr), .rx_overrun_o(ovr), .rs232_rxd_i(rxd),
      .rs232_txd_o(txd), .rs232_cts_i(cts), .rs232_rts_o(rts)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // bit 0 of bits goes on the line first, each bit held div cycles; rx_ready pulses at cycle rd_at
   task automatic drive_frame(input logic [15:0] bits, input int n, input int d, input int rd_at);
      for (int j = 0; j < n * d; j++) begin
         rxd_drv  = bits[j / d];
         rx_ready = (j == rd_at);
         @(negedge clk);
      end
      rxd_drv  = 1'b1;
      rx_ready = 1'b0;
   endtask

   task automatic do_read();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  pat;
      logic [15:0] fr;
      logic        seen;
      rst = 1; tx_en = 1; rx_en = 0; cts = 1; rxd_drv = 1; loop = 0;
      nbits = 2'b11; parity = 2'b00; stop2 = 0; div = 16'd4;
      tx_data = 8'h00; tx_valid = 0; rx_ready = 0;
      cyc(3);
      check("rst_txd", txd, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_perr", perr, 0);
      check("rst_ferr", ferr, 0);
      check("rst_ovr", ovr, 0);
      check("rst_rts", rts, 0);
      rst = 0; rx_en = 1;
      @(negedge clk);
      check("post_rst_tx_ready", tx_ready, 1);
      check("post_rst_rts", rts, 1);

      // 8N1 div=4, 0xA5; config changed mid-frame must not matter
      tx_data = 8'hA5; tx_valid = 1;
      @(negedge clk);
      tx_valid = 0; nbits = 2'b00; parity = 2'b01;
      pat = {1'b1, 8'hA5, 1'b0};
      check("a5_busy", tx_busy, 1);
      check("a5_ready_low", tx_ready, 0);
      for (int k = 0; k < 40; k++) begin
         check($sformatf("a5_txd_c%0d", k), txd, pat[k / 4]);
         @(negedge clk);
      end
      check("a5_ready_back", tx_ready, 1);
      check("a5_busy_done", tx_busy, 0);

      // loopback 7E2 div=16, 0x7F
      loop = 1; nbits = 2'b10; parity = 2'b01; stop2 = 1; div = 16'd16;
      @(negedge clk);
      tx_data = 8'h7F; tx_valid = 1;
      @(negedge clk);
      tx_valid = 0;
      seen = 0;
      for (int j = 0; j < 400; j++) begin
         if (j == 136) check("lb_parity_bit", txd, 1);
         if (rx_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      check("lb_valid_seen", seen, 1);
      check("lb_data", rx_data, 8'h7F);
      check("lb_perr", perr, 0);
      check("lb_ferr", ferr, 0);
      @(negedge clk);
      check("lb_rts_low", rts, 0);
      for (int j = 0; j < 100 && tx_busy; j++) @(negedge clk);
      check("lb_tx_done", tx_busy, 0);
      do_read();
      check("lb_read_clear", rx_valid, 0);
      loop = 0;

      // 8O1 div=8: good frame then one with a flipped data bit
      nbits = 2'b11; parity = 2'b10; stop2 = 0; div = 16'd8;
      @(negedge clk);
      drive_frame(16'h0606, 11, 8, -1);
      check("odd_ok_valid", rx_valid, 1);
      check("odd_ok_data", rx_data, 8'h03);
      check("odd_ok_perr", perr, 0);
      do_read();
      drive_frame(16'h060E, 11, 8, -1);
      check("odd_bad_data", rx_data, 8'h07);
      check("odd_bad_perr", perr, 1);
      check("odd_bad_ferr", ferr, 0);
      do_read();
      check("odd_read_perr_clr", perr, 0);

      // 8N1 frame error with the line held low afterwards
      parity = 2'b00;
      @(negedge clk);
      drive_frame(16'h00AA, 10, 8, -1);
      rxd_drv = 1'b0;
      check("fe_valid", rx_valid, 1);
      check("fe_data", rx_data, 8'h55);
      check("fe_ferr", ferr, 1);
      do_read();
      cyc(96);
      check("fe_break_hold", rx_valid, 0);
      rxd_drv = 1'b1;
      cyc(4);
      fr = {6'b0, 1'b1, 8'h3C, 1'b0};
      drive_frame(fr, 10, 8, -1);
      check("fe_after_data", rx_data, 8'h3C);
      check("fe_after_ferr", ferr, 0);
      do_read();

      // overrun, then a read landing exactly on the completion cycle
      fr = {6'b0, 1'b1, 8'h11, 1'b0};
      drive_frame(fr, 10, 8, -1);
      fr = {6'b0, 1'b1, 8'h22, 1'b0};
      drive_frame(fr, 10, 8, -1);
      check("ovr_data", rx_data, 8'h22);
      check("ovr_flag", ovr, 1);
      do_read();
      check("ovr_clear", ovr, 0);
      fr = {6'b0, 1'b1, 8'h33, 1'b0};
      drive_frame(fr, 10, 8, -1);
      check("rdc_first_valid", rx_valid, 1);
      fr = {6'b0, 1'b1, 8'h44, 1'b0};
      drive_frame(fr, 10, 8, 78);
      check("rdc_valid", rx_valid, 1);
      check("rdc_data", rx_data, 8'h44);
      check("rdc_ovr", ovr, 0);
      do_read();

      // 3-cycle glitch at div=16, then a real frame
      div = 16'd16;
      rxd_drv = 1'b0;
      cyc(3);
      rxd_drv = 1'b1;
      seen = 0;
      for (int j = 0; j < 200; j++) begin
         if (rx_valid) seen = 1;
         @(negedge clk);
      end
      check("glitch_no_valid", seen, 0);
      fr = {6'b0, 1'b1, 8'hC3, 1'b0};
      drive_frame(fr, 10, 16, -1);
      check("div16_data", rx_data, 8'hC3);
      check("div16_ferr", ferr, 0);
      do_read();

      // reset mid TX frame
      div = 16'd4;
      tx_data = 8'h00; tx_valid = 1;
      @(negedge clk);
      tx_valid = 0;
      cyc(10);
      check("rstmid_txd_pre", txd, 0);
      rst = 1;
      @(negedge clk);
      check("rstmid_txd", txd, 1);
      check("rstmid_busy", tx_busy, 0);
      check("rstmid_ready", tx_ready, 0);
      rst = 0;
      @(negedge clk);
      check("rstmid_ready_back", tx_ready, 1);
      cyc(40);
      check("rstmid_txd_idle", txd, 1);

      // CTS low blocks acceptance
      cts = 0;
      cyc(4);
      check("cts_ready_low", tx_ready, 0);
      tx_valid = 1;
      cyc(8);
      check("cts_not_busy", tx_busy, 0);
      check("cts_txd_idle", txd, 1);
      tx_valid = 0; cts = 1;
      cyc(4);
      check("cts_ready_back", tx_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/iob_uart_cfg_core.md
IOB_UART_CFG_CORE -- requirements
Module: iob_uart_cfg_core

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the bit-duration divisor and of the cycle counters.
REQ-002 SHALL have parameter SYNC_W, default 2: number of synchroniser flops on rs232_rxd_i and rs232_cts_i, minimum 2.
REQ-003 SHALL have one clock and one reset: clk_i input 1 is the sole clock, rising edge; rst_i input 1 is a synchronous, active-high reset.
REQ-004 SHALL have ports tx_en_i in 1 (transmitter enable) and rx_en_i in 1 (receiver enable).
REQ-005 SHALL have ports cfg_nbits_i in 2 (00=5, 01=6, 10=7, 11=8 data bits), cfg_parity_i in 2 (00/11=none, 01=even, 10=odd) and cfg_stop2_i in 1 (1 selects two stop bits).
REQ-006 SHALL have port bit_duration_i in DIV_W: clk_i cycles per bit; values below 2 are treated as 2.
REQ-007 SHALL have ports tx_data_i in 8, tx_valid_i in 1, tx_ready_o out 1 and tx_busy_o out 1.
REQ-008 SHALL have ports rx_data_o out 8, rx_valid_o out 1, rx_ready_i in 1, rx_parity_err_o out 1, rx_frame_err_o out 1 and rx_overrun_o out 1.
REQ-009 SHALL have ports rs232_rxd_i in 1, rs232_txd_o out 1, rs232_cts_i in 1 and rs232_rts_o out 1.

Function
REQ-010 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; each state bit lasts exactly max(bit_duration_i,2) cycles.
REQ-011 tx_ready_o SHALL be 1 only in IDLE with tx_en_i=1 and synchronised CTS=1; a transfer is accepted when tx_valid_i & tx_ready_o.
REQ-012 On acceptance: data, nbits, parity and stop config SHALL be latched; config changes mid-frame have no effect.
REQ-013 rs232_txd_o SHALL go low (start bit) on the cycle after acceptance; tx_ready_o and tx_busy_o SHALL update the same cycle.
REQ-014 Data SHALL be sent LSB first, nbits bits only; tx_data_i bits at or above nbits are ignored.
REQ-015 Parity bit SHALL be sent only when parity is enabled: even = XOR of sent data bits; odd = its inverse.
REQ-016 TX SHALL send 1 or 2 stop bits (high), then return to IDLE; tx_ready_o may reassert on the cycle after the last stop bit ends.
REQ-017 Deasserting tx_en_i or CTS mid-frame SHALL NOT abort the frame; both gate only new acceptances.
REQ-018 rs232_txd_o SHALL be registered and SHALL be 1 whenever TX is in IDLE.
REQ-019 RX SHALL pass rs232_rxd_i through SYNC_W flops reset to 1 and SHALL use only the synchronised value.
REQ-020 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, BREAK; IDLE leaves on synchronised rxd=0 with rx_en_i=1.
REQ-021 START SHALL wait floor(bit_duration/2) cycles then sample: 1 = glitch, return to IDLE with no flag; 0 = start confirmed.
REQ-022 Subsequent samples SHALL be taken every bit_duration cycles: nbits data bits LSB first, then parity if enabled, then the first stop bit.
REQ-023 Received data SHALL be right-aligned in rx_data_o with unused upper bits 0.
REQ-024 At the stop sample, rx_data_o, rx_valid_o=1 and the per-frame flags SHALL update together; rx_parity_err_o = parity mismatch; rx_frame_err_o = stop sample 0.
REQ-025 After a stop sample of 0, RX SHALL enter BREAK and wait for synchronised rxd=1 before IDLE; otherwise RX SHALL go directly to IDLE.
REQ-026 RX SHALL check only the first stop bit even when cfg_stop2_i=1.
REQ-027 rx_ready_i & rx_valid_o SHALL clear rx_valid_o, rx_parity_err_o, rx_frame_err_o and rx_overrun_o on the next cycle.
REQ-028 Frame completion while rx_valid_o=1 and rx_ready_i=0 SHALL overwrite the data and set rx_overrun_o.
REQ-029 Frame completion in the same cycle as a read SHALL leave the new data valid with rx_overrun_o=0.
REQ-030 rs232_rts_o SHALL be registered as rx_en_i & ~rx_valid_o.
REQ-031 rx_en_i=0 SHALL force RX to IDLE within one cycle, abandoning any partial frame without flags; rx_valid_o and the data hold.
REQ-032 All cycle counters SHALL be DIV_W wide and SHALL compare against the clamped divisor without wrap.

Reset
REQ-033 On rst_i=1 at a clk_i edge, both FSMs SHALL enter IDLE; this applies mid-frame, in which case the frame is abandoned.
REQ-034 Reset values SHALL be: rs232_txd_o=1, tx_ready_o=0, tx_busy_o=0, rx_valid_o=0, rx_data_o=0, all error flags 0, rs232_rts_o=0, synchroniser flops=1.
REQ-035 Outputs SHALL reach their functional values on the first cycle after rst_i deasserts.

Verification
REQ-036 Scenario: div=4, 8N1, send 0xA5 -> txd pattern 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; tx_ready_o back after 40 cycles.
REQ-037 Scenario: loopback txd->rxd, div=16, 7E2, send 0x7F -> rx_data_o=0x7F, parity bit transmitted 1, rx_parity_err_o=0.
REQ-038 Scenario: inject an odd-parity frame with one flipped data bit -> rx_parity_err_o=1; a frame with stop=0 -> rx_frame_err_o=1, and RX stays in BREAK until the line returns high.
REQ-039 Scenario: receive 0x11 then 0x22 with no read -> rx_data_o=0x22, rx_overrun_o=1; a read in the completion cycle -> rx_overrun_o=0.
REQ-040 Scenario: a 3-cycle low glitch at div=16 -> no rx_valid_o; rst_i pulse mid-TX-frame -> txd=1 next cycle; CTS=0 -> tx_valid_i not accepted.
